// File: rtl/move_frame_decoder_pkg.sv
// Shared constants and types for the move-link frame decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Frame layout: A5 header, {color, rsvd, move[21:16]}, move[15:8], move[7:0],
// then an XOR checksum over the three payload bytes.
package move_frame_decoder_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         MOVE_W    = 22;
  localparam int         COLOR_BIT = 7;
  localparam int         RSVD_BIT  = 6;

  // FSM encoding, kept as plain constants so older tools can read it
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GOT_HDR = 3'd1;
  localparam logic [2:0] ST_GOT_B1  = 3'd2;
  localparam logic [2:0] ST_GOT_B2  = 3'd3;
  localparam logic [2:0] ST_GOT_B3  = 3'd4;

  // Frame contents collected while the checksum byte is still outstanding
  typedef struct packed {
    logic              color;
    logic              rsvd;
    logic [MOVE_W-1:0] move;
  } shadow_t;

endpackage

// File: rtl/move_frame_decoder_byte_timeout.sv
// Inter-byte watchdog: flags when TIMEOUT_CYCLES pass with no byte in a frame.
// Latency: expired is combinational, high in the cycle whose edge makes the count reach the limit.
// Backpressure: none; clear (a new byte) always beats expiry on the same edge.
//
// Ports:
//   clock   in  system clock
//   reset   in  synchronous, active-low
//   enable  in  1 while a frame is in progress; 0 holds the count at zero
//   clear   in  restart the count (one byte received)
//   expired out one-cycle pulse as the count reaches TIMEOUT_CYCLES
module move_frame_decoder_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] LIMIT_M1 = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      // saturates at LIMIT so the pulse cannot repeat while waiting
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the edge that takes the count to LIMIT; never when a byte lands
  assign expired = enable && !clear && (cnt_q == LIMIT_M1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/move_frame_decoder.sv
// Receive-side decoder for the 5-byte move frame arriving as UART byte strobes.
// Latency: end_receive / frame_error pulse 1 cycle after the rx_finish carrying the checksum byte.
// Backpressure: none; every byte is consumed the cycle it is strobed.
//
// Ports:
//   clock, reset       system clock, synchronous active-low reset
//   rx_byte, rx_finish received byte and its one-cycle strobe
//   move_out, color    last good move and colour, held between frames
//   end_receive        one-cycle pulse when move_out/color update
//   frame_error        one-cycle pulse on bad checksum, reserved bit set, or timeout
//   busy               1 while a frame is being collected
module move_frame_decoder
  import move_frame_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_finish,
  output logic [MOVE_W-1:0] move_out,
  output logic              color,
  output logic              end_receive,
  output logic              frame_error,
  output logic              busy
);

  logic [2:0]        state_q, state_d;
  shadow_t           shadow_q, shadow_d;
  logic [7:0]        csum_q, csum_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic              color_q, color_d;
  logic              er_q, er_d;
  logic              fe_q, fe_d;
  logic              busy_q;
  logic              expired;

  move_frame_decoder_byte_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (state_q != ST_IDLE),
    .clear   (rx_finish),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    csum_d   = csum_q;
    move_d   = move_q;
    color_d  = color_q;
    er_d     = 1'b0;
    fe_d     = 1'b0;

    if (rx_finish) begin
      case (state_q)
        ST_IDLE: begin
          // non-header bytes in IDLE are line noise and dropped silently
          if (rx_byte == FRAME_HDR) begin
            state_d = ST_GOT_HDR;
            csum_d  = 8'h00;
          end
        end
        ST_GOT_HDR: begin
          shadow_d.color        = rx_byte[COLOR_BIT];
          shadow_d.rsvd         = rx_byte[RSVD_BIT];
          shadow_d.move[21:16]  = rx_byte[5:0];
          csum_d                = csum_q ^ rx_byte;
          state_d               = ST_GOT_B1;
        end
        ST_GOT_B1: begin
          shadow_d.move[15:8] = rx_byte;
          csum_d              = csum_q ^ rx_byte;
          state_d             = ST_GOT_B2;
        end
        ST_GOT_B2: begin
          shadow_d.move[7:0] = rx_byte;
          csum_d             = csum_q ^ rx_byte;
          state_d            = ST_GOT_B3;
        end
        ST_GOT_B3: begin
          if ((rx_byte == csum_q) && !shadow_q.rsvd) begin
            move_d  = shadow_q.move;
            color_d = shadow_q.color;
            er_d    = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expired) begin
      // stalled link: abandon the partial frame
      state_d = ST_IDLE;
      fe_d    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      csum_q   <= 8'h00;
      move_q   <= '0;
      color_q  <= 1'b0;
      er_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      csum_q   <= csum_d;
      move_q   <= move_d;
      color_q  <= color_d;
      er_q     <= er_d;
      fe_q     <= fe_d;
      // registered alongside the state so busy tracks it without lag
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign move_out    = move_q;
  assign color       = color_q;
  assign end_receive = er_q;
  assign frame_error = fe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_move_frame_decoder.sv
// Bench for move_frame_decoder: directed scenarios plus randomized frames,
// every cycle compared against a frame-level reference model.
module tb_move_frame_decoder;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_finish;
  logic [21:0] move_out;
  logic        color;
  logic        end_receive;
  logic        frame_error;
  logic        busy;

  always #5 clock = ~clock;

  move_frame_decoder #(
    .TIMEOUT_CYCLES (TO),
    .TO_W           (7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_finish   (rx_finish),
    .move_out    (move_out),
    .color       (color),
    .end_receive (end_receive),
    .frame_error (frame_error),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_er  = -100;
  int prev_er  = -100;

  // Reference model: bytes of the frame collected so far, plus idle gap
  logic [7:0]  mf_q[$];
  int          m_gap = 0;
  logic [21:0] m_move = '0;
  logic        m_color = 1'b0;
  logic        m_er = 1'b0;
  logic        m_fe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic fin, input logic [7:0] b);
    logic [7:0] b1, b2, b3, b4;
    m_er = 1'b0;
    m_fe = 1'b0;
    if (!rst_n) begin
      mf_q.delete();
      m_gap   = 0;
      m_move  = '0;
      m_color = 1'b0;
    end else if (fin) begin
      m_gap = 0;
      if (mf_q.size() != 0 || b == 8'hA5) mf_q.push_back(b);
      if (mf_q.size() == 5) begin
        b1 = mf_q[1]; b2 = mf_q[2]; b3 = mf_q[3]; b4 = mf_q[4];
        if (((b1 ^ b2 ^ b3) == b4) && (b1[6] == 1'b0)) begin
          m_move  = {b1[5:0], b2, b3};
          m_color = b1[7];
          m_er    = 1'b1;
        end else begin
          m_fe = 1'b1;
        end
        mf_q.delete();
      end
    end else if (mf_q.size() != 0) begin
      m_gap++;
      if (m_gap == TO) begin
        m_fe = 1'b1;
        mf_q.delete();
        m_gap = 0;
      end
    end
  endtask

  // One clock: drive at negedge, let the posedge happen, compare at next negedge
  task automatic tick(input logic rst_n, input logic fin, input logic [7:0] b);
    reset     = rst_n;
    rx_finish = fin;
    rx_byte   = b;
    model_step(rst_n, fin, b);
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (end_receive === 1'b1) begin
      prev_er = last_er;
      last_er = cyc;
    end
    chk("move_out",    32'(move_out),    32'(m_move));
    chk("color",       32'(color),       32'(m_color));
    chk("end_receive", 32'(end_receive), 32'(m_er));
    chk("frame_error", 32'(frame_error), 32'(m_fe));
    chk("busy",        32'(busy),        32'(mf_q.size() != 0));
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int gap);
    send(8'hA5); idle(gap);
    send(b1);    idle(gap);
    send(b2);    idle(gap);
    send(b3);    idle(gap);
    send(b4);
  endtask

  initial begin
    logic [7:0] r1, r2, r3, ck;
    int kind, gap;

    // Reset state
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'hA5);
    chk("rst_move",  32'(move_out),    32'h0);
    chk("rst_flags", {28'd0, color, end_receive, frame_error, busy}, 32'h0);

    // 1: good frame, checksum 95^34^12 = B3
    send_frame(8'h95, 8'h34, 8'h12, 8'hB3, 0);
    chk("s1_er",    32'(end_receive), 32'h1);
    chk("s1_move",  32'(move_out),    32'h153412);
    chk("s1_color", 32'(color),       32'h1);
    idle(1);

    // 2: bad checksum keeps previous move
    send_frame(8'h15, 8'h34, 8'h12, 8'h00, 0);
    chk("s2_fe",   32'(frame_error), 32'h1);
    chk("s2_move", 32'(move_out),    32'h153412);
    idle(1);
    chk("s2_busy", 32'(busy), 32'h0);

    // 3: junk ignored, then good frame
    send(8'h00); send(8'hFF); send(8'h5A);
    chk("s3_junk_busy", 32'(busy), 32'h0);
    send_frame(8'h03, 8'h00, 8'h01, 8'h02, 1);
    chk("s3_move",  32'(move_out), 32'h030001);
    chk("s3_color", 32'(color),    32'h0);

    // 4: timeout after B1, then recovery
    send(8'hA5); send(8'h01);
    idle(TO - 1);
    chk("s4_pre_fe", 32'(frame_error), 32'h0);
    idle(1);
    chk("s4_fe",   32'(frame_error), 32'h1);
    chk("s4_busy", 32'(busy),        32'h0);
    send_frame(8'h81, 8'h22, 8'h33, 8'h81 ^ 8'h22 ^ 8'h33, 0);
    chk("s4_move", 32'(move_out), 32'h012233);

    // byte arriving on the expiry edge wins
    send(8'hA5); idle(TO - 1); send(8'h05);
    chk("race_fe", 32'(frame_error), 32'h0);
    idle(TO);

    // 5: reset mid-frame discards it silently
    send(8'hA5); send(8'h01); send(8'h02);
    tick(1'b0, 1'b0, 8'h00);
    send(8'h00); send(8'h00);
    chk("s5_move", 32'(move_out), 32'h0);
    chk("s5_flags", {29'd0, end_receive, frame_error, busy}, 32'h0);

    // 6: reserved bit set with valid checksum
    send_frame(8'h07, 8'h08, 8'h09, 8'h07 ^ 8'h08 ^ 8'h09, 0);
    send_frame(8'h40, 8'h00, 8'h00, 8'h40, 0);
    chk("s6_fe",   32'(frame_error), 32'h1);
    chk("s6_move", 32'(move_out),    32'h070809);

    // 7: two frames back to back
    send_frame(8'h11, 8'h22, 8'h33, 8'h11 ^ 8'h22 ^ 8'h33, 0);
    send_frame(8'h9F, 8'hAA, 8'h55, 8'h9F ^ 8'hAA ^ 8'h55, 0);
    chk("s7_spacing", 32'(last_er - prev_er), 32'd5);
    chk("s7_move",    32'(move_out),          32'h1FAA55);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      gap  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 4, TO + 4) : $urandom_range(0, 2);
      r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      if (kind <= 4) r1[6] = 1'b0;
      if (kind == 6) r1[6] = 1'b1;
      ck = r1 ^ r2 ^ r3;
      if (kind == 5) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      case (kind)
        7: begin send(8'($urandom)); idle($urandom_range(0, 2)); end
        8: begin send(8'hA5); send(r1); tick(1'b0, 1'b0, 8'h00); end
        9: begin send(8'hA5); send(r1); send(r2); idle(TO + 2); end
        default: send_frame(r1, r2, r3, ck, gap);
      endcase
      idle($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
